eth_rx_frame_buf: RTL and testbench
===================================

Name: eth_rx_frame_buf

Overview:
- Receive frame buffer that sits directly downstream of the RMII receive stage.
- Accepts the byte stream and the end-of-frame CRC verdict, and stages each frame in a circular byte RAM.
- Commits only frames that have a good CRC and a legal length; rewinds the write pointer for bad ones.
- Replays committed frames on a valid/ready byte stream with a last-byte flag, for the MAC or user logic.

Parameters:
pADDR_WIDTH, 11, log2 of buffer depth in bytes (default 2048)
pLEN_DEPTH, 8, depth of the committed-frame length FIFO (power of 2)
pMIN_LEN, 64, minimum legal frame length in bytes, FCS included
pMAX_LEN, 1522, maximum legal frame length in bytes, FCS included

Ports:
Clk  in  1  single clock for all logic (50 MHz RMII domain)
Rst  in  1  synchronous, active-high reset
Byte_Rdy  in  1  one-cycle strobe; Byte is valid
Byte  in  8  received byte, first DA byte first, FCS bytes last
Frame_End  in  1  one-cycle strobe marking end of the current frame
Crc_Valid  in  1  CRC verdict, sampled only when Frame_End=1
Out_Valid  out  1  Out_Data is valid
Out_Data  out  8  frame byte
Out_Last  out  1  final byte of the frame (qualified by Out_Valid)
Out_Ready  in  1  consumer accepts the byte when Out_Valid&Out_Ready
Frame_Cnt  out  pLEN_DEPTH bits log2+1  committed frames not yet fully read
Drop_Cnt  out  8  count of dropped frames, saturates at 255
Overflow  out  1  one-cycle pulse when a frame is dropped for lack of buffer space or length-FIFO space

Behaviour:
- Reset values: Out_Valid=0, Out_Last=0, Out_Data=0, Frame_Cnt=0, Drop_Cnt=0, Overflow=0. All pointers and the length FIFO are cleared, and both FSMs go to IDLE.
- Reset is honoured mid-frame and mid-readout: any partial or committed content is discarded.
- Pointers: wr_commit, wr_tmp and rd_ptr are pADDR_WIDTH+1 bits wide, with MSB wrap. Used = wr_tmp - rd_ptr; full when Used = 2^pADDR_WIDTH. rd_ptr advances per accepted output byte, so space frees byte by byte.
- Write FSM, IDLE / WRITE / DROP:
  - IDLE:
    - Byte_Rdy: write Byte at wr_commit, wr_tmp=wr_commit+1, len=1, go to WRITE.
    - Frame_End alone: ignored, no count.
  - WRITE, on Byte_Rdy:
    - If full, or len = pMAX_LEN: go to DROP and pulse Overflow (full case only); the byte is not written.
    - Otherwise write at wr_tmp, wr_tmp+1, len+1.
  - WRITE, on Frame_End:
    - Commit if Crc_Valid=1, len>=pMIN_LEN and the length FIFO is not full. Commit means wr_commit<=wr_tmp and len is pushed.
    - Otherwise wr_tmp<=wr_commit, Drop_Cnt+1, and Overflow pulses if the cause was a full length FIFO.
    - Either way go to IDLE.
  - DROP: ignore Byte_Rdy. On Frame_End: wr_tmp<=wr_commit, Drop_Cnt+1, go to IDLE.
  - Byte_Rdy and Frame_End in the same cycle: the byte is written first, then the frame is evaluated including it.
- Read FSM, IDLE / LOAD / STREAM:
  - IDLE: when the length FIFO is non-empty, pop the length into rem and go to LOAD.
  - LOAD: issue the synchronous RAM read at rd_ptr and register the result into Out_Data. Out_Valid rises 2 cycles after the pop.
  - STREAM: hold Out_Data, Out_Valid and Out_Last stable until Out_Ready.
    - On accept: rd_ptr+1, rem-1, and the next byte is presented on the following cycle or later.
    - No bubble is required, but at most 1 bubble cycle per byte is permitted.
  - Out_Last=1 when rem=1. Accepting the last byte returns the FSM to IDLE and decrements Frame_Cnt.
- Latency: a commit on Frame_End at cycle T is visible to the reader at T+1; the first Out_Valid is no later than T+4.
- Frame_Cnt increments on commit and decrements on last-byte accept; when both happen in the same cycle it is unchanged.
- The RAM is single-write, single-read with a registered read. Write and read addresses never collide on live data, because the reader only consumes committed bytes.

Test Plan:
- Good frame: 64 bytes 0x00..0x3F, then Frame_End with Crc_Valid=1, Out_Ready=1 -> 64 beats 0x00..0x3F, Out_Last only on 0x3F, Frame_Cnt goes 1 then 0, Drop_Cnt=0.
- Bad CRC: 100-byte frame with Crc_Valid=0, followed by a good 64-byte frame -> only the 64-byte frame appears, Drop_Cnt=1, Overflow stays 0.
- Runt and giant: a 63-byte good-CRC frame and a 1523-byte frame -> both dropped, Drop_Cnt=2, no output.
- Overflow: Out_Ready=0, three 1000-byte good frames -> first two commit, third hits full and pulses Overflow once, Drop_Cnt=1, Frame_Cnt=2. Then Out_Ready=1 -> exactly 2000 bytes out, correct data.
- Back-pressure: random Out_Ready at 30% duty on a 1522-byte frame -> data and Out_Last stay stable while stalled, byte order is exact, no loss.
- Reset mid-frame: assert Rst at byte 40 of a frame while a previous frame is mid-readout -> all outputs are 0 the next cycle, Frame_Cnt=0. A new 64-byte frame afterwards is delivered intact.

Source files
------------

// File: rtl/eth_rx_frame_buf_if.sv
// Byte-stream bundle around the receive frame buffer: the receive-side byte
// strobes with the CRC verdict, and the valid/ready replay stream.
interface eth_rx_frame_buf_if;
    logic       Byte_Rdy;
    logic [7:0] Byte;
    logic       Frame_End;
    logic       Crc_Valid;
    logic       Out_Valid;
    logic [7:0] Out_Data;
    logic       Out_Last;
    logic       Out_Ready;

    // Buffer side: consumes received bytes, produces the replay stream.
    modport slave (
        input  Byte_Rdy, Byte, Frame_End, Crc_Valid, Out_Ready,
        output Out_Valid, Out_Data, Out_Last
    );

    // Environment side: feeds received bytes, consumes the replay stream.
    modport master (
        output Byte_Rdy, Byte, Frame_End, Crc_Valid, Out_Ready,
        input  Out_Valid, Out_Data, Out_Last
    );
endinterface

// File: rtl/eth_rx_frame_buf.sv
// Receive frame buffer: stages each incoming frame in a circular byte RAM,
// commits it only on a good CRC and legal length (rewinding otherwise), and
// replays committed frames on a valid/ready stream with a last-byte flag.
module eth_rx_frame_buf #(
    parameter int pADDR_WIDTH = 11,
    parameter int pLEN_DEPTH  = 8,
    parameter int pMIN_LEN    = 64,
    parameter int pMAX_LEN    = 1522
) (
    input  logic                          Clk,
    input  logic                          Rst,
    eth_rx_frame_buf_if.slave             bus,
    output logic [$clog2(pLEN_DEPTH):0]   Frame_Cnt,
    output logic [7:0]                    Drop_Cnt,
    output logic                          Overflow
);
    localparam int AW    = pADDR_WIDTH;
    localparam int DEPTH = 1 << AW;
    localparam int LAW   = $clog2(pLEN_DEPTH);
    localparam int LW    = $clog2(pMAX_LEN + 1);

    localparam logic [AW:0]   FULL_USED = {1'b1, {AW{1'b0}}};
    localparam logic [LAW:0]  LF_FULL   = (LAW+1)'(pLEN_DEPTH);
    localparam logic [LW-1:0] MIN_L     = LW'(pMIN_LEN);
    localparam logic [LW-1:0] MAX_L     = LW'(pMAX_LEN);
    localparam logic [LW-1:0] ONE_L     = LW'(1);

    typedef enum logic [1:0] {W_IDLE = 2'd0, W_WRITE = 2'd1, W_DROP = 2'd2} wr_state_t;
    typedef enum logic [1:0] {R_IDLE = 2'd0, R_LOAD = 2'd1, R_STREAM = 2'd2} rd_state_t;

    // Storage
    logic [7:0]    r_mem    [0:DEPTH-1];
    logic [LW-1:0] r_lf_mem [0:pLEN_DEPTH-1];
    logic [7:0]    r_rdata;

    // Write side state
    wr_state_t     r_wr_state;
    logic [AW:0]   r_wr_commit;
    logic [AW:0]   r_wr_tmp;
    logic [LW-1:0] r_len;
    logic [LAW:0]  r_lf_wr;
    logic [7:0]    r_drop_cnt;
    logic          r_overflow;

    // Read side state
    rd_state_t     r_rd_state;
    logic [AW:0]   r_rd_ptr;
    logic [LAW:0]  r_lf_rd;
    logic [LW-1:0] r_rem;
    logic          r_out_valid;
    logic          r_out_last;
    logic [7:0]    r_out_data;
    logic [LAW:0]  r_frame_cnt;

    // Combinational decisions
    logic [AW:0]   w_used;
    logic          w_full;
    logic          w_lf_full;
    logic          w_lf_empty;
    logic          w_byte_ok;
    logic          w_byte_rej;
    logic [LW-1:0] w_len_after;
    logic [AW:0]   w_tmp_after;
    logic          w_end;
    logic          w_frame_live;
    logic          w_len_ok;
    logic          w_commit;
    logic          w_overflow;
    logic          w_accept;
    logic          w_last_acc;
    logic [AW:0]   w_raddr;

    // Occupancy counts the staged (uncommitted) bytes too, so a growing frame
    // cannot overrun bytes the reader has not yet consumed.
    assign w_used     = r_wr_tmp - r_rd_ptr;
    assign w_full     = (w_used == FULL_USED);
    assign w_lf_full  = ((r_lf_wr - r_lf_rd) == LF_FULL);
    assign w_lf_empty = (r_lf_wr == r_lf_rd);

    // Decide whether an incoming byte is stored or forces the frame into DROP.
    // In IDLE the write pointer equals the commit point, so r_wr_tmp is used
    // as the write address in both IDLE and WRITE.
    always_comb begin
        w_byte_ok  = 1'b0;
        w_byte_rej = 1'b0;
        case (r_wr_state)
            W_IDLE: begin
                w_byte_ok  = bus.Byte_Rdy & ~w_full;
                w_byte_rej = bus.Byte_Rdy & w_full;
            end
            W_WRITE: begin
                w_byte_ok  = bus.Byte_Rdy & ~w_full & (r_len < MAX_L);
                w_byte_rej = bus.Byte_Rdy & (w_full | (r_len >= MAX_L));
            end
            default: begin
                w_byte_ok  = 1'b0;
                w_byte_rej = 1'b0;
            end
        endcase
    end

    // A byte arriving with Frame_End is counted into the frame before the
    // verdict; Frame_End with no frame in progress is ignored.
    assign w_len_after  = (r_wr_state == W_IDLE) ? ONE_L
                                                 : (r_len + {{(LW-1){1'b0}}, w_byte_ok});
    assign w_tmp_after  = r_wr_tmp + {{AW{1'b0}}, w_byte_ok};
    assign w_end        = bus.Frame_End & ((r_wr_state != W_IDLE) | bus.Byte_Rdy);
    assign w_frame_live = w_end & ~w_byte_rej & (r_wr_state != W_DROP);
    assign w_len_ok     = bus.Crc_Valid & (w_len_after >= MIN_L);
    assign w_commit     = w_frame_live & w_len_ok & ~w_lf_full;
    // Overflow flags space shortage only, never a CRC or length verdict.
    assign w_overflow   = (w_byte_rej & w_full) | (w_frame_live & w_len_ok & w_lf_full);

    assign w_accept   = (r_rd_state == R_STREAM) & bus.Out_Ready;
    assign w_last_acc = w_accept & r_out_last;
    // Look one byte ahead on accept so the next byte is already in r_rdata
    // when the reader re-enters LOAD.
    assign w_raddr    = w_accept ? (r_rd_ptr + {{AW{1'b0}}, 1'b1}) : r_rd_ptr;

    // Byte RAM and length FIFO storage: single write port, registered read.
    always_ff @(posedge Clk) begin
        if (w_byte_ok) begin
            r_mem[r_wr_tmp[AW-1:0]] <= bus.Byte;
        end
        if (w_commit) begin
            r_lf_mem[r_lf_wr[LAW-1:0]] <= w_len_after;
        end
        r_rdata <= r_mem[w_raddr[AW-1:0]];
    end

    // Write FSM: stage bytes, then commit or rewind on the frame verdict.
    always_ff @(posedge Clk) begin
        if (Rst) begin
            r_wr_state  <= W_IDLE;
            r_wr_commit <= '0;
            r_wr_tmp    <= '0;
            r_len       <= '0;
            r_lf_wr     <= '0;
            r_drop_cnt  <= 8'd0;
            r_overflow  <= 1'b0;
        end else begin
            r_overflow <= w_overflow;
            if (w_byte_ok) begin
                r_wr_tmp <= w_tmp_after;
                r_len    <= w_len_after;
            end
            if (w_end) begin
                r_wr_state <= W_IDLE;
                if (w_commit) begin
                    r_wr_commit <= w_tmp_after;
                    r_lf_wr     <= r_lf_wr + {{LAW{1'b0}}, 1'b1};
                end else begin
                    r_wr_tmp <= r_wr_commit;
                    if (r_drop_cnt != 8'hFF) begin
                        r_drop_cnt <= r_drop_cnt + 8'd1;
                    end
                end
            end else if (w_byte_rej) begin
                r_wr_state <= W_DROP;
            end else if (w_byte_ok) begin
                r_wr_state <= W_WRITE;
            end
        end
    end

    // Read FSM: pop a frame length, then present bytes one by one until the
    // last one is accepted.
    always_ff @(posedge Clk) begin
        if (Rst) begin
            r_rd_state  <= R_IDLE;
            r_rd_ptr    <= '0;
            r_lf_rd     <= '0;
            r_rem       <= '0;
            r_out_valid <= 1'b0;
            r_out_last  <= 1'b0;
            r_out_data  <= 8'd0;
        end else begin
            case (r_rd_state)
                R_IDLE: begin
                    if (!w_lf_empty) begin
                        r_rem      <= r_lf_mem[r_lf_rd[LAW-1:0]];
                        r_lf_rd    <= r_lf_rd + {{LAW{1'b0}}, 1'b1};
                        r_rd_state <= R_LOAD;
                    end
                end
                R_LOAD: begin
                    r_out_data  <= r_rdata;
                    r_out_valid <= 1'b1;
                    r_out_last  <= (r_rem == ONE_L);
                    r_rd_state  <= R_STREAM;
                end
                R_STREAM: begin
                    if (w_accept) begin
                        r_rd_ptr    <= r_rd_ptr + {{AW{1'b0}}, 1'b1};
                        r_rem       <= r_rem - ONE_L;
                        r_out_valid <= 1'b0;
                        r_out_last  <= 1'b0;
                        r_rd_state  <= r_out_last ? R_IDLE : R_LOAD;
                    end
                end
                default: begin
                    r_rd_state  <= R_IDLE;
                    r_out_valid <= 1'b0;
                    r_out_last  <= 1'b0;
                end
            endcase
        end
    end

    // Committed-but-unread frame counter; simultaneous commit and final
    // accept cancel out.
    always_ff @(posedge Clk) begin
        if (Rst) begin
            r_frame_cnt <= '0;
        end else begin
            case ({w_commit, w_last_acc})
                2'b10:   r_frame_cnt <= r_frame_cnt + {{LAW{1'b0}}, 1'b1};
                2'b01:   r_frame_cnt <= r_frame_cnt - {{LAW{1'b0}}, 1'b1};
                default: r_frame_cnt <= r_frame_cnt;
            endcase
        end
    end

    assign bus.Out_Valid = r_out_valid;
    assign bus.Out_Data  = r_out_data;
    assign bus.Out_Last  = r_out_last;
    assign Frame_Cnt     = r_frame_cnt;
    assign Drop_Cnt      = r_drop_cnt;
    assign Overflow      = r_overflow;
endmodule

// File: tb/tb_eth_rx_frame_buf.sv
// Directed bench for eth_rx_frame_buf: a vector table of single frames plus
// hand-written sequences for latency, overflow, back-pressure and reset.
module tb_eth_rx_frame_buf;
    logic       Clk;
    logic       Rst;
    logic [3:0] Frame_Cnt;
    logic [7:0] Drop_Cnt;
    logic       Overflow;

    eth_rx_frame_buf_if bus ();

    eth_rx_frame_buf dut (
        .Clk       (Clk),
        .Rst       (Rst),
        .bus       (bus),
        .Frame_Cnt (Frame_Cnt),
        .Drop_Cnt  (Drop_Cnt),
        .Overflow  (Overflow)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    typedef struct {
        int         len;
        logic [7:0] seed;
        logic       crc;
        logic       same_end;
        logic       exp_commit;
        int         exp_drop;
    } vec_t;

    vec_t       vecs [10];
    logic [8:0] got [$];
    logic [8:0] exp_q [$];
    int         n_checks = 0;
    int         n_err = 0;
    int         rdy_mode = 0;
    int         stall_viol = 0;
    int         ovf_pulses = 0;
    int         exp_drop = 0;
    logic       prev_stall = 1'b0;
    logic [7:0] prev_data = 8'd0;
    logic       prev_last = 1'b0;

    task automatic check(input string name, input int act, input int req);
        n_checks++;
        if (act !== req) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d", name, act, req);
        end
    endtask

    // Consumer: drives Out_Ready, records accepted beats, watches stalls.
    always @(negedge Clk) begin
        logic r;
        case (rdy_mode)
            0:       r = 1'b0;
            1:       r = 1'b1;
            default: r = ($urandom_range(0, 99) < 30);
        endcase
        bus.Out_Ready = r;
        if (prev_stall && (bus.Out_Valid !== 1'b1 || bus.Out_Data !== prev_data
                           || bus.Out_Last !== prev_last))
            stall_viol++;
        if (bus.Out_Valid === 1'b1 && r)
            got.push_back({bus.Out_Last, bus.Out_Data});
        prev_stall = (bus.Out_Valid === 1'b1) && !r;
        prev_data  = bus.Out_Data;
        prev_last  = bus.Out_Last;
        if (Overflow === 1'b1) ovf_pulses++;
    end

    task automatic send_frame(input int len, input logic [7:0] seed,
                              input logic crc, input logic same);
        for (int i = 0; i < len; i++) begin
            @(negedge Clk);
            bus.Byte_Rdy  = 1'b1;
            bus.Byte      = 8'(int'(seed) + i);
            bus.Frame_End = same && (i == len - 1);
            bus.Crc_Valid = crc;
        end
        if (!(same && len > 0)) begin
            @(negedge Clk);
            bus.Byte_Rdy  = 1'b0;
            bus.Frame_End = 1'b1;
            bus.Crc_Valid = crc;
        end
        @(negedge Clk);
        bus.Byte_Rdy  = 1'b0;
        bus.Frame_End = 1'b0;
        bus.Crc_Valid = 1'b0;
    endtask

    task automatic push_exp(input int len, input logic [7:0] seed);
        for (int i = 0; i < len; i++)
            exp_q.push_back({(i == len - 1), 8'(int'(seed) + i)});
    endtask

    task automatic drain(input string name, input int budget);
        int cyc = 0;
        int mism = 0;
        int n;
        while (got.size() < exp_q.size() && cyc < budget) begin
            @(negedge Clk);
            cyc++;
        end
        repeat (8) @(negedge Clk);
        check({name, "_count"}, got.size(), exp_q.size());
        n = (got.size() < exp_q.size()) ? got.size() : exp_q.size();
        for (int i = 0; i < n; i++)
            if (got[i] !== exp_q[i]) mism++;
        check({name, "_data"}, mism, 0);
        got.delete();
        exp_q.delete();
    endtask

    initial begin
        int lat;
        vecs[0] = '{64,   8'h00, 1'b1, 1'b0, 1'b1, 0};
        vecs[1] = '{100,  8'h10, 1'b0, 1'b0, 1'b0, 1};
        vecs[2] = '{64,   8'h80, 1'b1, 1'b0, 1'b1, 0};
        vecs[3] = '{63,   8'h20, 1'b1, 1'b0, 1'b0, 1};
        vecs[4] = '{1523, 8'h30, 1'b1, 1'b0, 1'b0, 1};
        vecs[5] = '{1522, 8'h40, 1'b1, 1'b0, 1'b1, 0};
        vecs[6] = '{0,    8'h00, 1'b1, 1'b0, 1'b0, 0};
        vecs[7] = '{64,   8'h55, 1'b1, 1'b1, 1'b1, 0};
        vecs[8] = '{63,   8'h66, 1'b1, 1'b1, 1'b0, 1};
        vecs[9] = '{65,   8'hF0, 1'b1, 1'b0, 1'b1, 0};

        bus.Byte_Rdy = 1'b0; bus.Byte = 8'd0; bus.Frame_End = 1'b0; bus.Crc_Valid = 1'b0;
        Rst = 1'b1;
        repeat (3) @(negedge Clk);
        check("rst_out_valid", bus.Out_Valid, 0);
        check("rst_out_last",  bus.Out_Last, 0);
        check("rst_out_data",  bus.Out_Data, 0);
        check("rst_frame_cnt", Frame_Cnt, 0);
        check("rst_drop_cnt",  Drop_Cnt, 0);
        check("rst_overflow",  Overflow, 0);
        Rst = 1'b0;
        rdy_mode = 1;
        repeat (2) @(negedge Clk);

        // Table of single frames, consumer always ready
        for (int v = 0; v < 10; v++) begin
            send_frame(vecs[v].len, vecs[v].seed, vecs[v].crc, vecs[v].same_end);
            if (vecs[v].exp_commit) push_exp(vecs[v].len, vecs[v].seed);
            exp_drop += vecs[v].exp_drop;
            drain($sformatf("vec%0d", v), 8000);
            check($sformatf("vec%0d_drop_cnt", v), Drop_Cnt, exp_drop);
            check($sformatf("vec%0d_frame_cnt", v), Frame_Cnt, 0);
            check($sformatf("vec%0d_no_ovf", v), ovf_pulses, 0);
        end

        // Commit-to-output latency and Frame_Cnt 1 -> 0
        rdy_mode = 0;
        repeat (2) @(negedge Clk);
        send_frame(64, 8'h00, 1'b1, 1'b1);
        lat = 0;
        for (int k = 2; k <= 10; k++) begin
            if (bus.Out_Valid === 1'b1 && lat == 0) lat = (k == 2) ? 1 : k - 1;
            @(negedge Clk);
        end
        check("latency_le4", (lat >= 1 && lat <= 4), 1);
        check("lat_frame_cnt1", Frame_Cnt, 1);
        check("lat_first_data", bus.Out_Data, 8'h00);
        check("lat_first_last", bus.Out_Last, 0);
        push_exp(64, 8'h00);
        rdy_mode = 1;
        drain("lat", 4000);
        check("lat_frame_cnt0", Frame_Cnt, 0);

        // Buffer overflow: third 1000-byte frame does not fit
        rdy_mode = 0;
        ovf_pulses = 0;
        repeat (2) @(negedge Clk);
        send_frame(1000, 8'h01, 1'b1, 1'b0);
        send_frame(1000, 8'h02, 1'b1, 1'b0);
        send_frame(1000, 8'h03, 1'b1, 1'b0);
        repeat (4) @(negedge Clk);
        exp_drop += 1;
        check("ovf_pulses",    ovf_pulses, 1);
        check("ovf_drop_cnt",  Drop_Cnt, exp_drop);
        check("ovf_frame_cnt", Frame_Cnt, 2);
        push_exp(1000, 8'h01);
        push_exp(1000, 8'h02);
        rdy_mode = 1;
        drain("ovf", 10000);
        check("ovf_frame_cnt0", Frame_Cnt, 0);

        // Back-pressure on a maximum-length frame
        rdy_mode = 2;
        stall_viol = 0;
        send_frame(1522, 8'h77, 1'b1, 1'b0);
        push_exp(1522, 8'h77);
        drain("bp", 30000);
        check("bp_stall_stable", stall_viol, 0);
        check("bp_frame_cnt", Frame_Cnt, 0);

        // Reset mid-frame while an earlier frame is mid-readout
        send_frame(200, 8'h11, 1'b1, 1'b0);
        for (int i = 0; i < 40; i++) begin
            @(negedge Clk);
            bus.Byte_Rdy = 1'b1;
            bus.Byte     = 8'(8'hC0 + i);
        end
        check("rst_mid_readout", Frame_Cnt, 1);
        @(negedge Clk);
        bus.Byte_Rdy = 1'b0;
        Rst = 1'b1;
        @(negedge Clk);
        check("mrst_out_valid", bus.Out_Valid, 0);
        check("mrst_out_last",  bus.Out_Last, 0);
        check("mrst_out_data",  bus.Out_Data, 0);
        check("mrst_frame_cnt", Frame_Cnt, 0);
        check("mrst_drop_cnt",  Drop_Cnt, 0);
        check("mrst_overflow",  Overflow, 0);
        Rst = 1'b0;
        got.delete();
        exp_q.delete();
        rdy_mode = 1;
        repeat (2) @(negedge Clk);
        got.delete();
        send_frame(64, 8'hA0, 1'b1, 1'b0);
        push_exp(64, 8'hA0);
        drain("post_rst", 4000);
        check("post_rst_drop_cnt", Drop_Cnt, 0);
        check("post_rst_frame_cnt", Frame_Cnt, 0);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end
endmodule
